// File: rtl/ann_weight_loader.sv
// Fetches one coefficient or image block from external memory, one outstanding
// read at a time, and streams each word into the ANN weight/image buffer.
module ann_weight_loader #(
  parameter int FIRST_LAYER  = 16,
  parameter int SECOND_LAYER = 8,
  parameter int THIRD_LAYER  = 10,
  parameter int IMAGE_SIZE   = 64,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] IMG_BASE = ADDR_WIDTH'('h0000),
  parameter logic [ADDR_WIDTH-1:0] L0_BASE  = ADDR_WIDTH'('h0040),
  parameter logic [ADDR_WIDTH-1:0] L1_BASE  = ADDR_WIDTH'('h0440),
  parameter logic [ADDR_WIDTH-1:0] L2_BASE  = ADDR_WIDTH'('h04C0),
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  request_coef,
  input  logic [1:0]            coef_select,
  input  logic                  start_detecting,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wr_en,
  output logic [10:0]           wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [1:0]            coef_set,
  output logic                  busy,
  output logic                  image_weights_loaded,
  output logic                  load_error
);

  localparam int CW = 11;
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] LAST_IMG = CW'(IMAGE_SIZE - 1);
  localparam logic [CW-1:0] LAST_L0  = CW'(FIRST_LAYER * IMAGE_SIZE - 1);
  localparam logic [CW-1:0] LAST_L1  = CW'(SECOND_LAYER * FIRST_LAYER - 1);
  localparam logic [CW-1:0] LAST_L2  = CW'(THIRD_LAYER * SECOND_LAYER - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_DATA, S_WRITE, S_DONE, S_ERROR
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [1:0]              coef_set_q, coef_set_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic [ADDR_WIDTH-1:0]   blk_base;
  logic [CW-1:0]           blk_last;
  logic [TW-1:0]           tmo_inc;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      tmo_q      <= '0;
      coef_set_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      coef_set_q <= coef_set_d;
      data_q     <= data_d;
    end
  end

  // Block geometry follows the latched select, never the live input.
  always_comb begin
    blk_base = IMG_BASE;
    blk_last = LAST_IMG;
    case (coef_set_q)
      2'b00:   begin blk_base = L0_BASE;  blk_last = LAST_L0;  end
      2'b01:   begin blk_base = L1_BASE;  blk_last = LAST_L1;  end
      2'b10:   begin blk_base = L2_BASE;  blk_last = LAST_L2;  end
      default: begin blk_base = IMG_BASE; blk_last = LAST_IMG; end
    endcase
  end

  assign tmo_inc = tmo_q + TW'(1);

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d    = state_q;
    count_d    = count_q;
    tmo_d      = tmo_q;
    coef_set_d = coef_set_q;
    data_d     = data_q;
    case (state_q)
      S_IDLE: begin
        if (request_coef) begin
          coef_set_d = coef_select;
          count_d    = '0;
          state_d    = S_ISSUE;
        end else if (start_detecting) begin
          coef_set_d = 2'b11;
          count_d    = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (mem_rvalid) begin
          data_d  = mem_rdata;
          state_d = S_WRITE;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TW'(TIMEOUT)) state_d = S_ERROR;
        end
      end
      S_WRITE: begin
        if (count_q == blk_last) begin
          state_d = S_DONE;
        end else begin
          count_d = count_q + CW'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state only; address/data buses rest at zero.
  always_comb begin
    mem_read             = 1'b0;
    mem_addr             = '0;
    wr_en                = 1'b0;
    wr_addr              = '0;
    wr_data              = '0;
    image_weights_loaded = 1'b0;
    load_error           = 1'b0;
    busy                 = (state_q != S_IDLE);
    case (state_q)
      S_ISSUE: begin
        mem_read = 1'b1;
        mem_addr = blk_base + ADDR_WIDTH'(count_q);
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = count_q;
        wr_data = data_q;
      end
      S_DONE:  image_weights_loaded = 1'b1;
      S_ERROR: load_error = 1'b1;
      default: ;
    endcase
  end

  assign coef_set = coef_set_q;

endmodule

// File: tb/tb_ann_weight_loader.sv
// Self-checking bench for ann_weight_loader: a latency-programmable memory
// responder plus a block-level model of the expected write stream and timing.
module tb_ann_weight_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        request_coef;
  logic [1:0]  coef_select;
  logic        start_detecting;
  logic        mem_read;
  logic [15:0] mem_addr;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  coef_set;
  logic        busy;
  logic        image_weights_loaded;
  logic        load_error;

  ann_weight_loader dut (
    .clk                  (clk),
    .rst                  (rst),
    .request_coef         (request_coef),
    .coef_select          (coef_select),
    .start_detecting      (start_detecting),
    .mem_read             (mem_read),
    .mem_addr             (mem_addr),
    .mem_rvalid           (mem_rvalid),
    .mem_rdata            (mem_rdata),
    .wr_en                (wr_en),
    .wr_addr              (wr_addr),
    .wr_data              (wr_data),
    .coef_set             (coef_set),
    .busy                 (busy),
    .image_weights_loaded (image_weights_loaded),
    .load_error           (load_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [0:2047];

  int r_writes, r_issues, r_done, r_err, r_first, r_last;
  bit r_aborted;

  function automatic int blk_words(input logic [1:0] s);
    case (s)
      2'b00:   return 16 * 64;
      2'b01:   return 8 * 16;
      2'b10:   return 10 * 8;
      default: return 64;
    endcase
  endfunction

  function automatic int blk_base(input logic [1:0] s);
    case (s)
      2'b00:   return 'h0040;
      2'b01:   return 'h0440;
      2'b10:   return 'h04C0;
      default: return 'h0000;
    endcase
  endfunction

  // Request at cycle 0, then observe each cycle on the falling edge and drive
  // the memory response for that cycle. Stops at DONE, ERROR, abort or budget.
  task automatic run_load(input bit req, input bit start, input logic [1:0] sel,
                          input int lat, input bit respond, input bit junk,
                          input int abort_after, input bit poke);
    logic [1:0]  eff;
    int          n, base, cyc, budget;
    int          due_q[$];
    logic [15:0] dat_q[$];
    eff    = req ? sel : 2'b11;
    n      = blk_words(eff);
    base   = blk_base(eff);
    budget = respond ? n * (lat + 2) + 20 : 300;
    r_writes = 0; r_issues = 0; r_done = -1; r_err = -1;
    r_first = -1; r_last = -1; r_aborted = 1'b0;
    request_coef    = req;
    start_detecting = start;
    coef_select     = sel;
    @(negedge clk);
    request_coef    = 1'b0;
    start_detecting = 1'b0;
    cyc = 1;
    while (cyc <= budget) begin
      n_cmp++;
      if (busy !== 1'b1) begin
        n_bad++; $display("FAIL busy_during_load cyc=%0d got=%b want=1", cyc, busy);
      end
      if (mem_read === 1'b1) begin
        n_cmp++;
        if (mem_addr !== 16'(base + r_issues)) begin
          n_bad++; $display("FAIL mem_addr word=%0d got=%h want=%h", r_issues, mem_addr, 16'(base + r_issues));
        end
        if (r_issues == 0) r_first = int'(mem_addr);
        r_last = int'(mem_addr);
        due_q.push_back(cyc + lat);
        dat_q.push_back(mem[mem_addr[10:0]]);
        r_issues++;
      end
      if (wr_en === 1'b1) begin
        n_cmp++;
        if (wr_addr !== 11'(r_writes) || wr_data !== mem[11'(base + r_writes)]) begin
          n_bad++; $display("FAIL write word=%0d got=%h/%h want=%h/%h", r_writes, wr_addr, wr_data,
                            11'(r_writes), mem[11'(base + r_writes)]);
        end
        r_writes++;
      end
      if (image_weights_loaded === 1'b1) begin r_done = cyc; break; end
      if (load_error === 1'b1) begin r_err = cyc; break; end
      if (abort_after > 0 && r_writes == abort_after) begin
        rst = 1'b1; r_aborted = 1'b1; break;
      end
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
      if (respond && due_q.size() > 0 && due_q[0] == cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = dat_q[0];
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end else if (junk && mem_read === 1'b1) begin
        mem_rvalid = 1'b1;
      end
      request_coef    = poke && (cyc == 5);
      start_detecting = poke && (cyc == 5);
      coef_select     = 2'($urandom);
      @(negedge clk);
      cyc++;
    end
    mem_rvalid      = 1'b0;
    request_coef    = 1'b0;
    start_detecting = 1'b0;
    if (cyc > budget) begin
      n_cmp++; n_bad++;
      $display("FAIL load_budget sel=%b got=no_end want=end_within_%0d", eff, budget);
    end else if (r_done >= 0 || r_err >= 0) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, image_weights_loaded, load_error} !== 3'b000) begin
        n_bad++; $display("FAIL back_to_idle got=%b want=000", {busy, image_weights_loaded, load_error});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; request_coef = 1'b0; start_detecting = 1'b0; coef_select = 2'b00;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_read, wr_en, busy, image_weights_loaded, load_error} !== 5'b0) begin
      n_bad++; $display("FAIL reset_strobes got=%b want=00000", {mem_read, wr_en, busy, image_weights_loaded, load_error});
    end
    n_cmp++;
    if ({mem_addr, wr_addr, wr_data, coef_set} !== 45'b0) begin
      n_bad++; $display("FAIL reset_buses got=%h/%h/%h/%b want=0", mem_addr, wr_addr, wr_data, coef_set);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_image_load();
    run_load(1'b0, 1'b1, 2'b00, 1, 1'b1, 1'b0, 0, 1'b0);
    n_cmp++;
    if (r_writes !== 64 || r_done !== 193) begin
      n_bad++; $display("FAIL image_load writes/done got=%0d/%0d want=64/193", r_writes, r_done);
    end
    n_cmp++;
    if (r_first !== 'h0 || r_last !== 'h3F || coef_set !== 2'b11) begin
      n_bad++; $display("FAIL image_addr_range got=%h..%h set=%b want=0000..003f set=11", r_first, r_last, coef_set);
    end
  endtask

  task automatic test_layer1_load();
    run_load(1'b1, 1'b0, 2'b01, 3, 1'b1, 1'b0, 0, 1'b0);
    n_cmp++;
    if (r_writes !== 128 || r_done !== 641) begin
      n_bad++; $display("FAIL layer1 writes/done got=%0d/%0d want=128/641", r_writes, r_done);
    end
    n_cmp++;
    if (r_first !== 'h440 || r_last !== 'h4BF || coef_set !== 2'b01) begin
      n_bad++; $display("FAIL layer1_addr_range got=%h..%h set=%b want=0440..04bf set=01", r_first, r_last, coef_set);
    end
  endtask

  task automatic test_busy_reject();
    run_load(1'b1, 1'b0, 2'b10, 2, 1'b1, 1'b0, 0, 1'b1);
    n_cmp++;
    if (r_writes !== 80 || r_issues !== 80 || r_done !== 1 + 80 * 4) begin
      n_bad++; $display("FAIL busy_reject writes/issues/done got=%0d/%0d/%0d want=80/80/321", r_writes, r_issues, r_done);
    end
    n_cmp++;
    if (coef_set !== 2'b10) begin
      n_bad++; $display("FAIL busy_reject_set got=%b want=10", coef_set);
    end
  endtask

  task automatic test_timeout();
    run_load(1'b1, 1'b0, 2'b01, 1, 1'b0, 1'b1, 0, 1'b0);
    n_cmp++;
    if (r_err !== 1 + 256 || r_done !== -1) begin
      n_bad++; $display("FAIL timeout err/done cycle got=%0d/%0d want=257/-1", r_err, r_done);
    end
    n_cmp++;
    if (r_writes !== 0 || r_issues !== 1 || coef_set !== 2'b01) begin
      n_bad++; $display("FAIL timeout writes/issues/set got=%0d/%0d/%b want=0/1/01", r_writes, r_issues, coef_set);
    end
  endtask

  task automatic test_reset_midload();
    bit seen;
    run_load(1'b1, 1'b0, 2'b00, 1, 1'b1, 1'b0, 10, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (r_aborted !== 1'b1 ||
        {mem_read, mem_addr, wr_en, wr_addr, wr_data, coef_set, busy, image_weights_loaded, load_error} !== '0) begin
      n_bad++; $display("FAIL midload_reset got=%b/%h/%b/%h/%h/%b/%b want=all_zero", mem_read, mem_addr,
                        wr_en, wr_addr, wr_data, coef_set, busy);
    end
    rst  = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (image_weights_loaded === 1'b1 || load_error === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL midload_quiet got=activity want=idle");
    end
    run_load(1'b1, 1'b0, 2'b00, 1, 1'b1, 1'b0, 0, 1'b0);
    n_cmp++;
    if (r_first !== 'h40 || r_writes !== 1024 || r_done !== 1 + 1024 * 3) begin
      n_bad++; $display("FAIL restart_layer0 first/writes/done got=%h/%0d/%0d want=0040/1024/3073", r_first, r_writes, r_done);
    end
  endtask

  task automatic test_priority();
    run_load(1'b1, 1'b1, 2'b10, 1, 1'b1, 1'b0, 0, 1'b0);
    n_cmp++;
    if (coef_set !== 2'b10 || r_first !== 'h4C0 || r_writes !== 80) begin
      n_bad++; $display("FAIL priority set/first/writes got=%b/%h/%0d want=10/04c0/80", coef_set, r_first, r_writes);
    end
  endtask

  task automatic test_random_loads();
    logic [1:0] sel, eff;
    bit         req;
    int         lat;
    for (int k = 0; k < 4; k++) begin
      sel = 2'($urandom);
      req = 1'($urandom);
      lat = int'($urandom_range(1, 4));
      eff = req ? sel : 2'b11;
      run_load(req, !req, sel, lat, 1'b1, 1'($urandom), 0, 1'b0);
      n_cmp++;
      if (r_writes !== blk_words(eff) || r_done !== 1 + blk_words(eff) * (lat + 2) || coef_set !== eff) begin
        n_bad++; $display("FAIL random_load%0d writes/done/set got=%0d/%0d/%b want=%0d/%0d/%b", k, r_writes,
                          r_done, coef_set, blk_words(eff), 1 + blk_words(eff) * (lat + 2), eff);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 64; i++)   mem[i] = 16'(32'h100 + i);
    test_reset();
    test_image_load();
    test_layer1_load();
    test_busy_reject();
    test_timeout();
    test_reset_midload();
    test_priority();
    test_random_loads();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
